gam_pattern_feeder: RTL and testbench
=====================================

Name: gam_pattern_feeder

Overview:
- Upstream stage of Memory_Layer. Buffers training and recall patterns, each a node vector plus a class index, in a small FIFO.
- Presents one pattern per Memory_Layer READY handshake on x/c. Raises learning_done together with the final pattern of a set.
- Replaces the behavioural stimulus loop that currently drives Memory_Layer, and rejects zero node or zero class entries at the write port.

Parameters:
- NODE_W, 32, width of node_vector_T (must match GAM_package)
- CLASS_W, 8, width of the class index carried internally; zero-extended to int on c
- DEPTH, 16, FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arms a new set; ignored unless state is IDLE or DONE
- mode_in  in  LEARNING_RECALL_T  mode latched on start
- wr_valid  in  1  write request
- wr_ready  out  1  FIFO can accept a write (not full)
- wr_node  in  NODE_W  pattern vector
- wr_class  in  CLASS_W  class index
- wr_last  in  1  marks the final pattern of the set
- ready_wait  in  READY_WAIT_T  from Memory_Layer; READY = can take next pattern
- x  out  node_vector_T  pattern to Memory_Layer
- c  out  int  class to Memory_Layer
- x_valid  out  1  one-cycle pulse when x/c update
- learning_done  out  1  to Memory_Layer
- learning_recall  out  LEARNING_RECALL_T  latched mode
- pattern_count  out  16  patterns presented since start
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- err_zero  out  1  sticky; a write with zero node or zero class was dropped

Behaviour:
- Reset (reset=0, async) values:
  - x=0, c=0, x_valid=0, learning_done=0, learning_recall=LEARNING.
  - pattern_count=0, level=0, err_zero=0, wr_ready=1.
  - FIFO empty, state IDLE.
- FIFO:
  - Entry = {wr_node, wr_class, wr_last}.
  - Push when wr_valid & wr_ready; wr_ready = (level != DEPTH).
  - Push at full is blocked even if a pop occurs in the same cycle.
  - A write with wr_node==0 or wr_class==0 is accepted but discarded: no push, err_zero set. err_zero clears only on reset or start.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when not full or empty: level unchanged.
- FSM states: IDLE, WAIT_READY, PRESENT, WAIT_BUSY, DONE.
  - IDLE/DONE --start--> WAIT_READY. On start: latch mode_in to learning_recall, clear pattern_count, clear learning_done, clear err_zero. FIFO contents are kept.
  - WAIT_READY: if ready_wait==READY and FIFO not empty, pop the head and go to PRESENT. If the FIFO is empty, wait indefinitely with no error.
  - PRESENT (1 cycle):
    - x <= head node; c <= head class zero-extended; x_valid=1; pattern_count++.
    - learning_done <= head.last & (learning_recall==LEARNING).
    - Go to DONE if head.last, else WAIT_BUSY.
  - WAIT_BUSY: stay until ready_wait==WAIT, then go to WAIT_READY. Exactly one pattern per READY pulse, even if READY is held.
  - DONE: hold x, c and learning_done; ignore ready_wait.
- Latency: ready_wait READY sampled at edge N -> pop at N -> x/c/x_valid valid after edge N+1.
- x and c hold their value between presentations; they are never driven to 0 after the first presentation.
- pattern_count saturates at 16'hFFFF.
- start while in WAIT_READY, PRESENT or WAIT_BUSY is ignored.
- Reset mid-set: FIFO flushed, all outputs return to reset values immediately (async).
- In RECALL mode, learning_done stays 0. DONE is still reached on wr_last.

Test Plan:
- Directed learning set:
  - Reset low 1 cycle, then write class 1 nodes 32'h0003, 32'h0400, 32'h070005, 32'h0101, 32'h0c0b0a09, 32'h0604 (the last with wr_last). Pulse start with LEARNING. Toggle ready_wait READY/WAIT 6 times.
  - Required: x follows the 6 values in order, c=1 each time, 6 x_valid pulses, pattern_count=6, learning_done=1 coincident with 32'h0604, state DONE.
- READY held high 10 cycles with 3 entries queued -> exactly 1 x_valid pulse, level drops 3->2.
- Fill to 16 entries:
  - wr_ready=0; a 17th write is not stored; level=16.
  - A write presented at full while the FSM pops -> write still refused in that cycle; accepted the next cycle; level returns to 16.
- Zero rejection:
  - Write node 0 with class 1 -> err_zero=1, level unchanged.
  - Write node 32'h0003 with class 0 -> dropped.
  - A following start -> err_zero=0.
- RECALL mode, 2 entries (the last with wr_last) -> 2 x_valid pulses, learning_recall=RECALL, learning_done stays 0, state DONE.
- Reset mid-set: assert reset during WAIT_BUSY after 3 presentations -> x=0, c=0, level=0, pattern_count=0 without waiting for a clock edge. After release, the FSM is IDLE.

Source files
------------

// File: rtl/gam_pattern_feeder.sv
// Pattern FIFO and handshake sequencer feeding Memory_Layer: buffers {node, class, last}
// entries and presents one pattern per READY pulse, flagging the end of a learning set.
module gam_pattern_feeder #(
  parameter int unsigned NODE_W  = 32,
  parameter int unsigned CLASS_W = 8,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode_in,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [NODE_W-1:0]        wr_node,
  input  logic [CLASS_W-1:0]       wr_class,
  input  logic                     wr_last,
  input  logic                     ready_wait,
  output logic [NODE_W-1:0]        x,
  output logic [31:0]              c,
  output logic                     x_valid,
  output logic                     learning_done,
  output logic                     learning_recall,
  output logic [15:0]              pattern_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_zero
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = NODE_W + CLASS_W + 1;
  localparam logic [AW:0] LvlFull    = (AW+1)'(DEPTH);
  // LEARNING_RECALL_T / READY_WAIT_T encodings
  localparam logic        LrLearning = 1'b0;
  localparam logic        RwReady    = 1'b1;
  localparam logic        RwWait     = 1'b0;

  typedef enum logic [2:0] {StIdle, StWaitReady, StPresent, StWaitBusy, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [AW:0]         r_level;
  logic [NODE_W-1:0]   r_head_node;
  logic [CLASS_W-1:0]  r_head_class;
  logic                r_head_last;
  logic [NODE_W-1:0]   r_x;
  logic [31:0]         r_c;
  logic                r_x_valid, r_done, r_mode, r_err;
  logic [15:0]         r_count;

  logic w_full, w_empty, w_nonzero, w_accept, w_push, w_drop, w_pop, w_start;

  assign w_full    = (r_level == LvlFull);
  assign w_empty   = (r_level == '0);
  assign w_nonzero = (|wr_node) && (|wr_class);
  assign w_accept  = wr_valid && !w_full;
  assign w_push    = w_accept && w_nonzero;
  assign w_drop    = w_accept && !w_nonzero;
  assign w_pop     = (r_state == StWaitReady) && (ready_wait == RwReady) && !w_empty;
  assign w_start   = start && ((r_state == StIdle) || (r_state == StDone));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: if (w_start) w_state_d = StWaitReady;
      StWaitReady:    if (w_pop) w_state_d = StPresent;
      StPresent:      w_state_d = r_head_last ? StDone : StWaitBusy;
      StWaitBusy:     if (ready_wait == RwWait) w_state_d = StWaitReady;
      default:        w_state_d = StIdle;
    endcase
  end

  // Storage array has no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {wr_node, wr_class, wr_last};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_head_node  <= '0;
      r_head_class <= '0;
      r_head_last  <= 1'b0;
      r_x          <= '0;
      r_c          <= '0;
      r_x_valid    <= 1'b0;
      r_done       <= 1'b0;
      r_mode       <= LrLearning;
      r_err        <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state   <= w_state_d;
      r_x_valid <= (r_state == StPresent);
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        {r_head_node, r_head_class, r_head_last} <= r_mem[r_rptr];
      end
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
      if (w_start) begin
        r_mode  <= mode_in;
        r_count <= '0;
        r_done  <= 1'b0;
      end
      // A dropped write in the same cycle as start still leaves the error visible
      if (w_drop)       r_err <= 1'b1;
      else if (w_start) r_err <= 1'b0;
      if (r_state == StPresent) begin
        r_x    <= r_head_node;
        r_c    <= 32'(r_head_class);
        r_done <= r_head_last && (r_mode == LrLearning);
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
    end
  end

  assign wr_ready        = !w_full;
  assign x               = r_x;
  assign c               = r_c;
  assign x_valid         = r_x_valid;
  assign learning_done   = r_done;
  assign learning_recall = r_mode;
  assign pattern_count   = r_count;
  assign level           = r_level;
  assign err_zero        = r_err;

endmodule

// File: tb/tb_gam_pattern_feeder.sv
// Self-checking bench for gam_pattern_feeder: FIFO model plus presentation scoreboard,
// table-driven learning set and directed multi-cycle corner cases.
module tb_gam_pattern_feeder;

  logic        clk = 1'b0;
  logic        reset, start, mode_in, wr_valid, wr_last, ready_wait;
  logic        wr_ready, x_valid, learning_done, learning_recall, err_zero;
  logic [31:0] wr_node, x, c;
  logic [7:0]  wr_class;
  logic [15:0] pattern_count;
  logic [4:0]  level;

  gam_pattern_feeder #(.NODE_W(32), .CLASS_W(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_node(wr_node), .wr_class(wr_class),
    .wr_last(wr_last), .ready_wait(ready_wait), .x(x), .c(c), .x_valid(x_valid),
    .learning_done(learning_done), .learning_recall(learning_recall),
    .pattern_count(pattern_count), .level(level), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] node; logic [7:0] cls; logic last;} ent_t;
  typedef struct {logic [31:0] x; logic [31:0] c; logic ld;} exp_t;
  typedef struct {logic [31:0] node; logic [7:0] cls; logic last; logic exp_done;} vec_t;

  ent_t model[$];
  exp_t sb[$];
  vec_t tbl[6];
  int   checks = 0, errors = 0, n_xv = 0;
  logic cur_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (x_valid === 1'b1) begin
      exp_t e;
      n_xv++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_x_valid: got x=%0h with empty scoreboard", x);
      end else begin
        e = sb.pop_front();
        if (x !== e.x || c !== e.c || learning_done !== e.ld) begin
          errors++;
          $display("FAIL presentation: got x=%0h c=%0h ld=%0b expected x=%0h c=%0h ld=%0b",
                   x, c, learning_done, e.x, e.c, e.ld);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] n, input logic [7:0] cl, input logic l);
    logic acc;
    wr_valid = 1'b1; wr_node = n; wr_class = cl; wr_last = l;
    acc = wr_ready;
    tick();
    wr_valid = 1'b0;
    if (acc && n != 0 && cl != 0) model.push_back('{n, cl, l});
  endtask

  task automatic do_start(input logic m, input logic takes);
    start = 1'b1; mode_in = m;
    tick();
    start = 1'b0;
    if (takes) cur_mode = m;
  endtask

  task automatic expect_pop();
    ent_t e;
    if (model.size() > 0) begin
      e = model.pop_front();
      sb.push_back('{e.node, 32'(e.cls), e.last & (cur_mode == 1'b0)});
    end
  endtask

  task automatic ready_pulse(input logic pops);
    if (pops) expect_pop();
    ready_wait = 1'b1;
    tick();
    ready_wait = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int xv0;
    tbl[0] = '{32'h0003,     8'd1, 1'b0, 1'b0};
    tbl[1] = '{32'h0400,     8'd1, 1'b0, 1'b0};
    tbl[2] = '{32'h070005,   8'd1, 1'b0, 1'b0};
    tbl[3] = '{32'h0101,     8'd1, 1'b0, 1'b0};
    tbl[4] = '{32'h0c0b0a09, 8'd1, 1'b0, 1'b0};
    tbl[5] = '{32'h0604,     8'd1, 1'b1, 1'b1};

    reset = 1'b0; start = 1'b0; mode_in = 1'b0; wr_valid = 1'b0; wr_node = '0;
    wr_class = '0; wr_last = 1'b0; ready_wait = 1'b0;
    #1;
    check("rst_x", x, 0);
    check("rst_c", c, 0);
    check("rst_x_valid", {31'b0, x_valid}, 0);
    check("rst_learning_done", {31'b0, learning_done}, 0);
    check("rst_learning_recall", {31'b0, learning_recall}, 0);
    check("rst_pattern_count", {16'b0, pattern_count}, 0);
    check("rst_level", {27'b0, level}, 0);
    check("rst_err_zero", {31'b0, err_zero}, 0);
    check("rst_wr_ready", {31'b0, wr_ready}, 1);
    tick();
    reset = 1'b1;
    tick();

    // Directed learning set
    for (int i = 0; i < 6; i++) wr(tbl[i].node, tbl[i].cls, tbl[i].last);
    check("learn_level", {27'b0, level}, 6);
    do_start(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ready_pulse(1'b1);
      check("learn_x", x, tbl[i].node);
      check("learn_c", c, 32'(tbl[i].cls));
      check("learn_done", {31'b0, learning_done}, {31'b0, tbl[i].exp_done});
    end
    check("learn_xv_count", n_xv, 6);
    check("learn_pattern_count", {16'b0, pattern_count}, 6);
    // DONE ignores READY
    wr(32'h77, 8'd9, 1'b0);
    ready_pulse(1'b0);
    check("done_no_xv", n_xv, 6);
    check("done_level", {27'b0, level}, 1);
    check("done_hold_x", x, 32'h0604);
    check("done_hold_ld", {31'b0, learning_done}, 1);

    // READY held high with 3 entries
    wr(32'h88, 8'd2, 1'b0);
    wr(32'h99, 8'd3, 1'b0);
    do_start(1'b0, 1'b1);
    check("start_clears_count", {16'b0, pattern_count}, 0);
    check("start_clears_ld", {31'b0, learning_done}, 0);
    xv0 = n_xv;
    expect_pop();
    ready_wait = 1'b1;
    repeat (10) tick();
    ready_wait = 1'b0;
    repeat (2) tick();
    check("held_one_xv", n_xv - xv0, 1);
    check("held_level", {27'b0, level}, 2);

    // Fill to full, overflow, push-at-full with pop
    for (int i = 0; i < 14; i++) wr(32'h1000 + i, 8'(i + 1), 1'b0);
    check("full_level", {27'b0, level}, 16);
    check("full_wr_ready", {31'b0, wr_ready}, 0);
    wr(32'hdead, 8'd7, 1'b0);
    check("overflow_level", {27'b0, level}, 16);
    expect_pop();
    wr_valid = 1'b1; wr_node = 32'hbeef; wr_class = 8'd5; wr_last = 1'b0;
    ready_wait = 1'b1;
    tick();
    ready_wait = 1'b0;
    check("fullpop_level", {27'b0, level}, 15);
    check("fullpop_wr_ready", {31'b0, wr_ready}, 1);
    tick();
    wr_valid = 1'b0;
    model.push_back('{32'hbeef, 8'd5, 1'b0});
    check("fullpop_refill", {27'b0, level}, 16);
    repeat (2) tick();
    for (int i = 0; i < 16; i++) ready_pulse(1'b1);
    check("drain_level", {27'b0, level}, 0);
    check("drain_model", model.size(), 0);

    // Zero rejection; start ignored outside IDLE/DONE
    wr(32'h0, 8'd1, 1'b0);
    check("zero_node_err", {31'b0, err_zero}, 1);
    check("zero_node_level", {27'b0, level}, 0);
    do_start(1'b1, 1'b0);
    check("busy_start_err", {31'b0, err_zero}, 1);
    check("busy_start_mode", {31'b0, learning_recall}, 0);
    wr(32'h0003, 8'd0, 1'b0);
    check("zero_class_level", {27'b0, level}, 0);
    wr(32'h5, 8'd2, 1'b1);
    ready_pulse(1'b1);
    check("count_since_start", {16'b0, pattern_count}, 19);
    do_start(1'b1, 1'b1);
    check("start_clears_err", {31'b0, err_zero}, 0);
    check("recall_mode", {31'b0, learning_recall}, 1);

    // RECALL set
    xv0 = n_xv;
    wr(32'h11, 8'd3, 1'b0);
    wr(32'h22, 8'd4, 1'b1);
    ready_pulse(1'b1);
    ready_pulse(1'b1);
    check("recall_xv", n_xv - xv0, 2);
    check("recall_ld", {31'b0, learning_done}, 0);
    check("recall_count", {16'b0, pattern_count}, 2);
    wr(32'h33, 8'd5, 1'b0);
    ready_pulse(1'b0);
    check("recall_done_no_xv", n_xv - xv0, 2);
    check("recall_done_x", x, 32'h22);
    check("recall_done_c", c, 4);

    // Reset during WAIT_BUSY after 3 presentations
    do_start(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) wr(32'h200 + i, 8'd6, 1'b0);
    ready_pulse(1'b1);
    ready_pulse(1'b1);
    expect_pop();
    ready_wait = 1'b1;
    repeat (3) tick();
    check("pre_reset_count", {16'b0, pattern_count}, 3);
    #2 reset = 1'b0;
    #1;
    check("midrst_x", x, 0);
    check("midrst_c", c, 0);
    check("midrst_level", {27'b0, level}, 0);
    check("midrst_count", {16'b0, pattern_count}, 0);
    check("midrst_wr_ready", {31'b0, wr_ready}, 1);
    ready_wait = 1'b0;
    model.delete();
    cur_mode = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    xv0 = n_xv;
    wr(32'h44, 8'd6, 1'b0);
    ready_pulse(1'b0);
    check("idle_no_xv", n_xv - xv0, 0);
    check("idle_level", {27'b0, level}, 1);
    do_start(1'b0, 1'b1);
    ready_pulse(1'b1);
    check("post_rst_xv", n_xv - xv0, 1);
    check("post_rst_x", x, 32'h44);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
